load_store_unit: RTL

Initiator side of the data-memory port. It accepts one load or store request at a time from the CPU datapath and converts byte addresses to word indices. Byte and halfword stores are done as read-modify-write, because the data memory only handles whole words. Byte and halfword loads are extracted and extended from the returned word. It sits between the execute stage and the data memory, drives the memory's `Address`/`WriteData`/`MemRead`/`MemWrite` inputs, and consumes its registered `ReadData`.

---
 rtl/load_store_unit_if.sv | 30 +++
 rtl/load_store_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Bundle of CPU request/response and data-memory port signals for the load/store unit.
// The slave modport is the load/store unit itself; the master modport is the
// surrounding environment (execute stage plus data memory).
interface load_store_unit_if;
    logic        Req;
    logic        IsStore;
    logic [1:0]  Size;
    logic        Signed;
    logic [31:0] ByteAddr;
    logic [31:0] StoreData;
    logic        Ready;
    logic        Done;
    logic        Fault;
    logic [31:0] LoadData;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] MemReadData;

    modport slave (
        input  Req, IsStore, Size, Signed, ByteAddr, StoreData, MemReadData,
        output Ready, Done, Fault, LoadData, MemAddress, MemWriteData, MemRead, MemWrite
    );

    modport master (
        output Req, IsStore, Size, Signed, ByteAddr, StoreData, MemReadData,
        input  Ready, Done, Fault, LoadData, MemAddress, MemWriteData, MemRead, MemWrite
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, byte address to word index conversion,
// read-modify-write for byte/halfword stores, extraction and extension for loads.
module load_store_unit #(
    parameter int MEM_WORDS = 32
) (
    input logic               Clk,
    input logic               Reset,
    load_store_unit_if.slave  bus
);

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        is_store_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  offset_q;
    logic [15:0] store_data_q;
    logic        fault_q;
    logic [31:0] load_data_q;
    logic [31:0] mem_address_q;
    logic [31:0] mem_write_data_q;

    logic        req_fault;
    logic        accept;
    logic        word_store;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign accept     = (state == IDLE) && bus.Req;
    assign word_store = bus.IsStore && (bus.Size == 2'b10);

    // Classify the incoming request: illegal size, misalignment or out-of-range word.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a value first, so no path can infer a latch.
        req_fault = 1'b0;
        case (bus.Size)
            2'b01:   req_fault = bus.ByteAddr[0];
            2'b10:   req_fault = |bus.ByteAddr[1:0];
            2'b11:   req_fault = 1'b1;
            default: req_fault = 1'b0;
        endcase
        if ({2'b00, bus.ByteAddr[31:2]} >= MEM_WORDS_W) begin
            req_fault = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore outputs; enables are decoded straight from the state.
    always_comb begin
        state_next   = state;
        bus.Ready    = 1'b0;
        bus.Done     = 1'b0;
        bus.Fault    = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        case (state)
            IDLE: begin
                bus.Ready = 1'b1;
                if (bus.Req) begin
                    if (req_fault) begin
                        state_next = DONE;
                    end else if (word_store) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ: begin
                bus.MemRead = 1'b1;
                state_next  = WAIT;
            end
            WAIT: begin
                state_next = is_store_q ? WRITE : DONE;
            end
            WRITE: begin
                bus.MemWrite = 1'b1;
                state_next   = DONE;
            end
            DONE: begin
                bus.Done   = 1'b1;
                bus.Fault  = fault_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Lane extraction with extension for loads, and lane merge for partial stores.
    always_comb begin
        case (offset_q)
            2'd0:    rd_byte = bus.MemReadData[7:0];
            2'd1:    rd_byte = bus.MemReadData[15:8];
            2'd2:    rd_byte = bus.MemReadData[23:16];
            default: rd_byte = bus.MemReadData[31:24];
        endcase
        rd_half = offset_q[1] ? bus.MemReadData[31:16] : bus.MemReadData[15:0];

        case (size_q)
            2'b00:   load_ext = {{24{signed_q & rd_byte[7]}}, rd_byte};
            2'b01:   load_ext = {{16{signed_q & rd_half[15]}}, rd_half};
            default: load_ext = bus.MemReadData;
        endcase

        merged = bus.MemReadData;
        if (size_q == 2'b00) begin
            case (offset_q)
                2'd0:    merged[7:0]   = store_data_q[7:0];
                2'd1:    merged[15:8]  = store_data_q[7:0];
                2'd2:    merged[23:16] = store_data_q[7:0];
                default: merged[31:24] = store_data_q[7:0];
            endcase
        end else if (offset_q[1]) begin
            merged[31:16] = store_data_q;
        end else begin
            merged[15:0] = store_data_q;
        end
    end

    // Request capture on accept, and result/merged-word capture while read data is valid.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            is_store_q       <= 1'b0;
            size_q           <= 2'b00;
            signed_q         <= 1'b0;
            offset_q         <= 2'b00;
            store_data_q     <= 16'h0000;
            fault_q          <= 1'b0;
            load_data_q      <= 32'h0000_0000;
            mem_address_q    <= 32'h0000_0000;
            mem_write_data_q <= 32'h0000_0000;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (accept) begin
                is_store_q    <= bus.IsStore;
                size_q        <= bus.Size;
                signed_q      <= bus.Signed;
                offset_q      <= bus.ByteAddr[1:0];
                store_data_q  <= bus.StoreData[15:0];
                fault_q       <= req_fault;
                mem_address_q <= {2'b00, bus.ByteAddr[31:2]};
                if (!req_fault && word_store) begin
                    mem_write_data_q <= bus.StoreData;
                end
            end
            if (state == WAIT) begin
                if (is_store_q) begin
                    mem_write_data_q <= merged;
                end else begin
                    load_data_q <= load_ext;
                end
            end
        end
    end

    assign bus.LoadData     = load_data_q;
    assign bus.MemAddress   = mem_address_q;
    assign bus.MemWriteData = mem_write_data_q;

endmodule
